// File: rtl/edge_setup.sv
// Edge-function setup for a two-triangle quad: captures vertices per frame, computes line-0 edges
// with one shared multiplier, then steps them per line. EDGE_SETUP_TRI2_EN enables tri 2 (v0,v2,v3).
module edge_setup #(
    parameter int H_LOAD    = 640,
    parameter int Y_CAPTURE = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic signed [9:0]  x_v0,
    input  logic signed [9:0]  x_v1,
    input  logic signed [9:0]  x_v2,
    input  logic signed [9:0]  x_v3,
    input  logic signed [9:0]  y_v0,
    input  logic signed [9:0]  y_v1,
    input  logic signed [9:0]  y_v2,
    input  logic signed [9:0]  y_v3,
    output logic signed [19:0] e0_init_t1,
    output logic signed [19:0] e1_init_t1,
    output logic signed [19:0] e2_init_t1,
    output logic signed [19:0] e0_init_t2,
    output logic signed [19:0] e1_init_t2,
    output logic signed [19:0] e2_init_t2,
    output logic signed [19:0] y_screen_v0,
    output logic signed [19:0] y_screen_v1,
    output logic signed [19:0] y_screen_v2,
    output logic signed [19:0] y_screen_v3,
    output logic               busy,
    output logic               setup_err
);

`ifdef EDGE_SETUP_TRI2_EN
    localparam int NUM_EDGES = 6;
`else
    localparam int NUM_EDGES = 3;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_n;
    logic signed [9:0]  cap_x [4];
    logic signed [9:0]  cap_y [4];
    logic signed [9:0]  act_x [4];
    logic signed [19:0] shadow [6];
    logic signed [19:0] e_init [6];
    logic signed [19:0] y_scr [4];
    logic [2:0]         k;
    logic               phase;
    logic signed [19:0] acc;
    logic signed [19:0] prod;
    logic signed [9:0]  mul_a, mul_b;
    logic signed [9:0]  v3x, v3y;
    logic [1:0]         ia, ib;
    logic               capture, load, step;

    // Edge k uses vertex pair (a,b); entries 0..2 are tri 1, 3..5 are tri 2.
    function automatic logic [1:0] vert_a(input int i);
        case (i)
            0: return 2'd0;
            1: return 2'd1;
            2: return 2'd2;
            3: return 2'd0;
            4: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] vert_b(input int i);
        case (i)
            0: return 2'd1;
            1: return 2'd2;
            2: return 2'd0;
            3: return 2'd2;
            4: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic signed [19:0] sext(input logic signed [9:0] v);
        return {{10{v[9]}}, v};
    endfunction

`ifdef EDGE_SETUP_TRI2_EN
    assign v3x = x_v3;
    assign v3y = y_v3;
`else
    logic unused_v3;
    assign unused_v3 = ^{x_v3, y_v3};
    assign v3x = '0;
    assign v3y = '0;
`endif

    assign capture = (y == 10'(Y_CAPTURE)) && (x == 10'd0);
    assign load    = (y == 10'd524) && (x == 10'(H_LOAD));
    assign step    = (y <= 10'd478) && (x == 10'(H_LOAD));
    assign busy    = (state != IDLE);

    // Cycle A multiplies ya*xb, cycle B multiplies xa*yb for the current edge.
    always_comb begin
        ia    = vert_a(int'(k));
        ib    = vert_b(int'(k));
        mul_a = phase ? cap_x[ia] : cap_y[ia];
        mul_b = phase ? cap_y[ib] : cap_x[ib];
    end

    assign prod = sext(mul_a) * sext(mul_b);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = IDLE;
            MUL:     if (phase && (k == 3'(NUM_EDGES - 1))) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (capture) state_n = MUL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            phase <= 1'b0;
            acc   <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
        end else if (capture) begin
            k     <= '0;
            phase <= 1'b0;
            acc   <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
        end else if (state == MUL) begin
            if (!phase) begin
                acc   <= prod;
                phase <= 1'b1;
            end else begin
                shadow[k] <= acc - prod;
                k         <= k + 3'd1;
                phase     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cap_x[i] <= '0;
                cap_y[i] <= '0;
            end
        end else if (capture) begin
            cap_x[0] <= x_v0;
            cap_x[1] <= x_v1;
            cap_x[2] <= x_v2;
            cap_x[3] <= v3x;
            cap_y[0] <= y_v0;
            cap_y[1] <= y_v1;
            cap_y[2] <= y_v2;
            cap_y[3] <= v3y;
        end
    end

    // Outputs move only at the load column: frame load on row 524, incremental step on rows 0..478.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_err <= 1'b0;
            for (int i = 0; i < 6; i++) e_init[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                act_x[i] <= '0;
                y_scr[i] <= '0;
            end
        end else if (load) begin
            if (busy) setup_err <= 1'b1;
            for (int i = 0; i < NUM_EDGES; i++) e_init[i] <= shadow[i];
            for (int i = 0; i < 4; i++) begin
                act_x[i] <= cap_x[i];
                y_scr[i] <= sext(cap_y[i]);
            end
        end else if (step) begin
            for (int i = 0; i < NUM_EDGES; i++)
                e_init[i] <= e_init[i] + sext(act_x[vert_a(i)]) - sext(act_x[vert_b(i)]);
        end
    end

    assign e0_init_t1  = e_init[0];
    assign e1_init_t1  = e_init[1];
    assign e2_init_t1  = e_init[2];
    assign e0_init_t2  = e_init[3];
    assign e1_init_t2  = e_init[4];
    assign e2_init_t2  = e_init[5];
    assign y_screen_v0 = y_scr[0];
    assign y_screen_v1 = y_scr[1];
    assign y_screen_v2 = y_scr[2];
    assign y_screen_v3 = y_scr[3];

endmodule

// File: tb/tb_edge_setup.sv
// Randomized bench for edge_setup: outputs are predicted from the closed-form edge equation
// evaluated at the current line, plus hand-computed vectors that pin that prediction.
module tb_edge_setup;

`ifdef EDGE_SETUP_TRI2_EN
    localparam bit TRI2 = 1'b1;
`else
    localparam bit TRI2 = 1'b0;
`endif
    localparam int H_LOAD    = 640;
    localparam int Y_CAPTURE = 480;
    localparam int BUSY_LEN  = TRI2 ? 13 : 7;
    localparam int EA [6] = '{0, 1, 2, 0, 2, 3};
    localparam int EB [6] = '{1, 2, 0, 2, 3, 0};

    logic               clk;
    logic               rst_n;
    logic [9:0]         x, y;
    logic signed [9:0]  x_v0, x_v1, x_v2, x_v3, y_v0, y_v1, y_v2, y_v3;
    logic signed [19:0] e0_t1, e1_t1, e2_t1, e0_t2, e1_t2, e2_t2;
    logic signed [19:0] ysv0, ysv1, ysv2, ysv3;
    logic               busy, setup_err;
    logic signed [19:0] e_dut [6];
    logic signed [19:0] ys_dut [4];

    int vx [4];
    int vy [4];
    int cap_mx [4];
    int cap_my [4];
    int act_mx [4];
    int act_my [4];
    int m_line, m_busy_cnt;
    bit m_err, started, e_chk;
    int checks, errors;
    string e_names [6] = '{"e0_t1", "e1_t1", "e2_t1", "e0_t2", "e1_t2", "e2_t2"};

    edge_setup #(.H_LOAD(H_LOAD), .Y_CAPTURE(Y_CAPTURE)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .x_v0(x_v0), .x_v1(x_v1), .x_v2(x_v2), .x_v3(x_v3),
        .y_v0(y_v0), .y_v1(y_v1), .y_v2(y_v2), .y_v3(y_v3),
        .e0_init_t1(e0_t1), .e1_init_t1(e1_t1), .e2_init_t1(e2_t1),
        .e0_init_t2(e0_t2), .e1_init_t2(e1_t2), .e2_init_t2(e2_t2),
        .y_screen_v0(ysv0), .y_screen_v1(ysv1), .y_screen_v2(ysv2), .y_screen_v3(ysv3),
        .busy(busy), .setup_err(setup_err)
    );

    assign x_v0 = 10'(vx[0]);
    assign x_v1 = 10'(vx[1]);
    assign x_v2 = 10'(vx[2]);
    assign x_v3 = 10'(vx[3]);
    assign y_v0 = 10'(vy[0]);
    assign y_v1 = 10'(vy[1]);
    assign y_v2 = 10'(vy[2]);
    assign y_v3 = 10'(vy[3]);
    assign e_dut[0] = e0_t1;
    assign e_dut[1] = e1_t1;
    assign e_dut[2] = e2_t1;
    assign e_dut[3] = e0_t2;
    assign e_dut[4] = e1_t2;
    assign e_dut[5] = e2_t2;
    assign ys_dut[0] = ysv0;
    assign ys_dut[1] = ysv1;
    assign ys_dut[2] = ysv2;
    assign ys_dut[3] = ysv3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // e(0,L) = (0-xa)(yb-ya) - (L-ya)(xb-xa), wrapped to 20 bits.
    function automatic int edge_val(input int xa, input int ya, input int xb, input int yb, input int line);
        logic signed [19:0] r;
        r = 20'((0 - xa) * (yb - ya) - (line - ya) * (xb - xa));
        return int'(r);
    endfunction

    function automatic int exp_e(input int i);
        if (i >= 3 && !TRI2) return 0;
        return edge_val(act_mx[EA[i]], act_my[EA[i]], act_mx[EB[i]], act_my[EB[i]], m_line);
    endfunction

    function automatic int exp_ys(input int i);
        if (i == 3 && !TRI2) return 0;
        return act_my[i];
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            cap_mx[i] = 0; cap_my[i] = 0; act_mx[i] = 0; act_my[i] = 0;
        end
        m_line = 0;
        m_busy_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic randomize_vertices();
        for (int i = 0; i < 4; i++) begin
            vx[i] = int'($urandom_range(1023, 0)) - 512;
            vy[i] = int'($urandom_range(1023, 0)) - 512;
        end
    endtask

    // One clock at raster position (nx, ny); the model follows the same edge.
    task automatic apply_stimulus(input int nx, input int ny);
        bit was_busy;
        x = 10'(nx);
        y = 10'(ny);
        @(posedge clk);
        if (rst_n) begin
            was_busy = (m_busy_cnt > 0);
            if (ny == Y_CAPTURE && nx == 0) begin
                for (int i = 0; i < 4; i++) begin
                    cap_mx[i] = vx[i];
                    cap_my[i] = vy[i];
                end
                m_busy_cnt = BUSY_LEN;
            end else if (m_busy_cnt > 0) begin
                m_busy_cnt--;
            end
            if (ny == 524 && nx == H_LOAD) begin
                if (was_busy) m_err = 1'b1;
                act_mx = cap_mx;
                act_my = cap_my;
                m_line = 0;
            end
            if (ny <= 478 && nx == H_LOAD) m_line++;
        end
        #2;
        randomize_vertices();
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_output("busy", int'(busy), int'(m_busy_cnt > 0));
            check_output("setup_err", int'(setup_err), int'(m_err));
            for (int i = 0; i < 4; i++) check_output("y_screen", int'(ys_dut[i]), exp_ys(i));
            if (e_chk) for (int i = 0; i < 6; i++) check_output(e_names[i], int'(e_dut[i]), exp_e(i));
        end
    end

    // kind 0: random vertices, 1: triangle (100,50)/(300,50)/(200,250), 2: extreme tri-2 corners.
    task automatic run_frame(input int kind);
        int busy_seen;
        int rx;
        apply_stimulus(0, Y_CAPTURE);
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_seen++;
            apply_stimulus(c + 1, Y_CAPTURE);
        end
        check_output("busy_len", busy_seen, BUSY_LEN);
        apply_stimulus(H_LOAD, 479);
        apply_stimulus(H_LOAD, 500);
        apply_stimulus(H_LOAD, 523);
        apply_stimulus(100, 524);
        apply_stimulus(H_LOAD, 524);
        if (kind == 1) begin
            check_output("lit_e0_line0", int'(e0_t1), 10000);
            check_output("lit_e1_line0", int'(e1_t1), -65000);
            check_output("lit_e2_line0", int'(e2_t1), 15000);
            check_output("lit_ysv0", int'(ysv0), 50);
            check_output("lit_ysv1", int'(ysv1), 50);
            check_output("lit_ysv2", int'(ysv2), 250);
        end
        if (kind == 2) begin
            check_output("lit_e0_t2", int'(e0_t2), TRI2 ? -25550 : 0);
            check_output("lit_e1_t2", int'(e1_t2), 0);
            check_output("lit_e2_t2", int'(e2_t2), TRI2 ? -25600 : 0);
        end
        apply_stimulus(799, 524);
        for (int line = 0; line <= 478; line++) begin
            apply_stimulus(H_LOAD, line);
            if (kind == 1 && line == 0) begin
                check_output("lit_e0_line1", int'(e0_t1), 9800);
                check_output("lit_e1_line1", int'(e1_t1), -64900);
                check_output("lit_e2_line1", int'(e2_t1), 15100);
            end
            if (kind == 1 && line == 99) check_output("lit_e0_line100", int'(e0_t1), -10000);
            apply_stimulus(799, line);
            rx = int'($urandom_range(799, 0));
            if (rx == H_LOAD) rx = 0;
            apply_stimulus(rx, line);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        started = 1'b0;
        e_chk = 1'b1;
        x = '0;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            vx[i] = 0; vy[i] = 0;
        end
        model_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 started = 1'b1;
        apply_stimulus(5, 10);
        apply_stimulus(6, 10);
        rst_n = 1'b1;
        check_output("reset_e0", int'(e0_t1), 0);
        check_output("reset_busy", int'(busy), 0);

        vx = '{100, 300, 200, 0};
        vy = '{50, 50, 250, 0};
        run_frame(1);

        // Asynchronous reset in the middle of the multiply sequence.
        apply_stimulus(0, Y_CAPTURE);
        for (int c = 1; c <= 3; c++) apply_stimulus(c, Y_CAPTURE);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("async_busy", int'(busy), 0);
        check_output("async_e0_t1", int'(e0_t1), 0);
        check_output("async_e1_t1", int'(e1_t1), 0);
        check_output("async_e2_t1", int'(e2_t1), 0);
        check_output("async_ysv2", int'(ysv2), 0);
        apply_stimulus(10, Y_CAPTURE);
        apply_stimulus(11, Y_CAPTURE);
        rst_n = 1'b1;
        for (int c = 12; c < 27; c++) apply_stimulus(c, Y_CAPTURE);
        check_output("idle_after_reset", int'(busy), 0);

        vx[0] = 100;  vy[0] = 50;
        vx[2] = 511;  vy[2] = 511;
        vx[3] = -512; vy[3] = -512;
        run_frame(2);

        for (int f = 0; f < 5; f++) begin
            randomize_vertices();
            run_frame(0);
        end

        // Load point reached while the multiply sequence is still running.
        apply_stimulus(0, Y_CAPTURE);
        for (int c = 1; c <= 3; c++) apply_stimulus(c, Y_CAPTURE);
        e_chk = 1'b0;
        apply_stimulus(H_LOAD, 524);
        check_output("setup_err_set", int'(setup_err), 1);
        for (int c = 0; c < 20; c++) apply_stimulus(700, 524);
        check_output("setup_err_sticky", int'(setup_err), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("setup_err_clear", int'(setup_err), 0);
        apply_stimulus(5, 5);
        rst_n = 1'b1;
        e_chk = 1'b1;
        for (int c = 0; c < 3; c++) apply_stimulus(5, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
